// File: rtl/riscv_clmul_pkg.sv
// Shared encodings, FSM state type and parameter sanity check for the iterative carry-less multiplier.
package riscv_clmul_pkg;

    localparam logic [1:0] CLMUL_OP_LO  = 2'b00;
    localparam logic [1:0] CLMUL_OP_HI  = 2'b01;
    localparam logic [1:0] CLMUL_OP_REV = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } clmul_state_e;

    function automatic bit clmul_width_ok(input int width, input int digit_bits);
        return (digit_bits >= 1) && (digit_bits <= width) && ((width % digit_bits) == 0);
    endfunction

endpackage

// File: rtl/riscv_clmul_digit.sv
// One digit step: XOR of a shifted by (base + j) for every set bit j of the digit; purely combinational.
// Zero latency; no handshake, the caller sequences digits.
module riscv_clmul_digit #(
    parameter int WIDTH      = 32,
    parameter int DIGIT_BITS = 4,
    parameter int SHW        = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0]      a_i,
    input  logic [DIGIT_BITS-1:0] digit_i,
    input  logic [SHW-1:0]        base_i,
    output logic [2*WIDTH-1:0]    partial_o
);

    logic [2*WIDTH-1:0] a_ext;

    assign a_ext = {{WIDTH{1'b0}}, a_i};

    always_comb begin
        partial_o = '0;
        for (int j = 0; j < DIGIT_BITS; j++) begin
            if (digit_i[j]) begin
                partial_o = partial_o ^ (a_ext << (int'(base_i) + j));
            end
        end
    end

endmodule

// File: rtl/riscv_clmul_iter.sv
// Iterative carry-less multiplier: DIGIT_BITS of op_b per cycle, full product plus lo/hi/rev word.
// Latency N+1 edges (1 on a zero operand); one op in flight, result held until out_ready_i, kill_i aborts.
module riscv_clmul_iter #(
    parameter int WIDTH      = 32,
    parameter int DIGIT_BITS = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             kill_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] result_l_o,
    output logic [WIDTH-1:0] result_h_o
);
    import riscv_clmul_pkg::*;

    localparam int N     = WIDTH / DIGIT_BITS;
    localparam int CNT_W = $clog2(N) + 1;
    localparam int SHW   = $clog2(WIDTH) + 1;

    if (!clmul_width_ok(WIDTH, DIGIT_BITS)) begin : g_bad_params
        $error("riscv_clmul_iter: WIDTH must be a non-zero multiple of DIGIT_BITS");
    end

    clmul_state_e       state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d, b_shift;
    logic [1:0]         op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, partial;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   res_l_q, res_l_d;
    logic [WIDTH-1:0]   res_h_q, res_h_d;
    logic [WIDTH-1:0]   sel;
    logic [SHW-1:0]     base;

    // b is consumed from the bottom, so the current digit is always b_q[DIGIT_BITS-1:0]
    if (DIGIT_BITS == WIDTH) begin : g_b_shift_full
        assign b_shift = '0;
    end else begin : g_b_shift
        assign b_shift = {{DIGIT_BITS{1'b0}}, b_q[WIDTH-1:DIGIT_BITS]};
    end

    assign base = SHW'(cnt_q) * SHW'(DIGIT_BITS);

    riscv_clmul_digit #(
        .WIDTH      (WIDTH),
        .DIGIT_BITS (DIGIT_BITS),
        .SHW        (SHW)
    ) u_digit (
        .a_i       (a_q),
        .digit_i   (b_q[DIGIT_BITS-1:0]),
        .base_i    (base),
        .partial_o (partial)
    );

    always_comb begin
        sel = acc_q[WIDTH-1:0];
        case (op_q)
            CLMUL_OP_HI:  sel = acc_q[2*WIDTH-1:WIDTH];
            CLMUL_OP_REV: sel = acc_q[2*WIDTH-2:WIDTH-1];
            default:      sel = acc_q[WIDTH-1:0];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;
        res_l_d     = res_l_q;
        res_h_d     = res_h_q;

        if (kill_i) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            cnt_d       = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        a_d     = op_a_i;
                        b_d     = op_b_i;
                        op_d    = op_i;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ((op_a_i == '0) || (op_b_i == '0)) ? DONE : CALC;
                    end
                end
                CALC: begin
                    acc_d = acc_q ^ partial;
                    b_d   = b_shift;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(N - 1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    // first DONE cycle registers the results; valid then holds until the handshake
                    if (!out_valid_q) begin
                        out_valid_d = 1'b1;
                        res_d       = sel;
                        res_l_d     = acc_q[WIDTH-1:0];
                        res_h_d     = acc_q[2*WIDTH-1:WIDTH];
                    end else if (out_ready_i) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= CLMUL_OP_LO;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            res_l_q     <= '0;
            res_h_q     <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            res_l_q     <= res_l_d;
            res_h_q     <= res_h_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = out_valid_q;
    assign result_o    = res_q;
    assign result_l_o  = res_l_q;
    assign result_h_o  = res_h_q;

endmodule

// File: tb/tb_riscv_clmul_iter.sv
// Bench for riscv_clmul_iter at DIGIT_BITS 1, 4 and 32: queued expectations checked by a per-instance monitor.
module tb_riscv_clmul_iter;

    localparam int W = 32;

    typedef struct {
        logic [31:0] res;
        logic [31:0] l;
        logic [31:0] h;
        int          acc_cyc;
        int          lat;
        int          id;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    task automatic chk(input int db, input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL db%0d %s: got %0h required %0h", db, name, got, exp);
        end
    endtask

    function automatic logic [63:0] clmul_ref(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        p = '0;
        for (int i = 0; i < 32; i++) begin
            if (y[i]) p = p ^ (64'(x) << i);
        end
        return p;
    endfunction

    function automatic logic [31:0] ref_sel(input logic [1:0] o, input logic [63:0] p);
        case (o)
            2'b01:   return p[63:32];
            2'b10:   return p[62:31];
            default: return p[31:0];
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gb
        localparam int DB = (g == 0) ? 1 : ((g == 1) ? 4 : 32);
        localparam int N  = W / DB;
        localparam int KC = (N > 3) ? 3 : N - 1;

        logic        rst, kill, in_valid, in_ready, out_valid, out_ready;
        logic [1:0]  op;
        logic [31:0] a, b, res, rl, rh;
        logic        prev_v = 1'b0;
        exp_t        q[$];

        riscv_clmul_iter #(.WIDTH(W), .DIGIT_BITS(DB)) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .kill_i      (kill),
            .in_valid_i  (in_valid),
            .in_ready_o  (in_ready),
            .op_i        (op),
            .op_a_i      (a),
            .op_b_i      (b),
            .out_valid_o (out_valid),
            .out_ready_i (out_ready),
            .result_o    (res),
            .result_l_o  (rl),
            .result_h_o  (rh)
        );

        always @(negedge clk) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL db%0d unexpected_output: got out_valid=1 required 0", DB);
                end else begin
                    if (!prev_v)
                        chk(DB, $sformatf("latency_id%0d", q[0].id), 64'(cyc - q[0].acc_cyc), 64'(q[0].lat));
                    if (out_ready) begin
                        chk(DB, $sformatf("result_id%0d", q[0].id), 64'(res), 64'(q[0].res));
                        chk(DB, $sformatf("result_l_id%0d", q[0].id), 64'(rl), 64'(q[0].l));
                        chk(DB, $sformatf("result_h_id%0d", q[0].id), 64'(rh), 64'(q[0].h));
                        void'(q.pop_front());
                    end
                end
            end
            prev_v <= out_valid;
        end

        task automatic wait_ready();
            int t = 0;
            while (!in_ready && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                n_checks++;
                n_fail++;
                $display("FAIL db%0d ready_timeout: got in_ready=0 required 1", DB);
            end
        endtask

        task automatic start(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
            wait_ready();
            op = o;
            a = x;
            b = y;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
        endtask

        task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                             input logic [31:0] eres, input logic [31:0] el, input logic [31:0] eh,
                             input int id);
            exp_t e;
            wait_ready();
            e.res     = eres;
            e.l       = el;
            e.h       = eh;
            e.acc_cyc = cyc + 1;
            e.lat     = ((x == 0) || (y == 0)) ? 1 : N + 1;
            e.id      = id;
            q.push_back(e);
            start(o, x, y);
        endtask

        task automatic drain();
            int t = 0;
            while (q.size() != 0 && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (q.size() != 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL db%0d drain_timeout: got %0d pending required 0", DB, q.size());
            end
        endtask

        initial begin
            logic [63:0] p;
            logic [31:0] x, y;
            logic [1:0]  o;
            int          t;

            rst = 1'b1; kill = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
            op = 2'b00; a = '0; b = '0;
            repeat (2) @(negedge clk);
            chk(DB, "reset_in_ready", 64'(in_ready), 64'd1);
            chk(DB, "reset_out_valid", 64'(out_valid), 64'd0);
            chk(DB, "reset_result", 64'(res), 64'd0);
            chk(DB, "reset_result_l", 64'(rl), 64'd0);
            chk(DB, "reset_result_h", 64'(rh), 64'd0);
            rst = 1'b0;

            issue(2'b00, 32'h3, 32'h3, 32'h5, 32'h5, 32'h0, 1);
            issue(2'b11, 32'h3, 32'h3, 32'h5, 32'h5, 32'h0, 2);
            issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555, 32'h5555_5555, 32'h5555_5555, 3);
            issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555, 32'h5555_5555, 32'h5555_5555, 4);
            issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h5555_5555, 32'h5555_5555, 5);
            issue(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, 32'h4000_0000, 6);
            issue(2'b10, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h4000_0000, 7);
            issue(2'b00, 32'h5, 32'h7, 32'h1B, 32'h1B, 32'h0, 8);
            issue(2'b01, 32'hDEAD_BEEF, 32'h10, 32'hD, 32'hEADB_EEF0, 32'hD, 9);
            issue(2'b00, 32'h0, 32'h1234, 32'h0, 32'h0, 32'h0, 10);
            issue(2'b01, 32'h1234, 32'h0, 32'h0, 32'h0, 32'h0, 11);
            drain();

            // consumer stall: results and handshake signals must hold
            out_ready = 1'b0;
            issue(2'b00, 32'hDEAD_BEEF, 32'h10, 32'hEADB_EEF0, 32'hEADB_EEF0, 32'hD, 12);
            t = 0;
            while (!out_valid && t < 100) begin
                @(negedge clk);
                t++;
            end
            for (int k = 0; k < 5; k++) begin
                chk(DB, "stall_out_valid", 64'(out_valid), 64'd1);
                chk(DB, "stall_in_ready", 64'(in_ready), 64'd0);
                chk(DB, "stall_result", 64'(res), 64'hEADB_EEF0);
                chk(DB, "stall_result_h", 64'(rh), 64'hD);
                @(negedge clk);
            end
            out_ready = 1'b1;
            drain();

            // kill during CALC, then kill racing a request in IDLE
            start(2'b00, 32'h3, 32'h3);
            repeat (KC) @(negedge clk);
            kill = 1'b1;
            @(negedge clk);
            kill = 1'b0;
            chk(DB, "kill_in_ready", 64'(in_ready), 64'd1);
            chk(DB, "kill_out_valid", 64'(out_valid), 64'd0);
            a = 32'h3; b = 32'h3; op = 2'b00;
            in_valid = 1'b1; kill = 1'b1;
            @(negedge clk);
            in_valid = 1'b0; kill = 1'b0;
            chk(DB, "kill_blocks_accept", 64'(in_ready), 64'd1);
            repeat (N + 3) @(negedge clk);
            issue(2'b00, 32'h5, 32'h7, 32'h1B, 32'h1B, 32'h0, 13);
            drain();

            start(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            repeat (KC) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk(DB, "rst_in_ready", 64'(in_ready), 64'd1);
            chk(DB, "rst_out_valid", 64'(out_valid), 64'd0);
            chk(DB, "rst_result", 64'(res), 64'd0);
            repeat (N + 3) @(negedge clk);
            issue(2'b01, 32'hDEAD_BEEF, 32'h10, 32'hD, 32'hEADB_EEF0, 32'hD, 14);
            drain();

            for (int i = 0; i < 6; i++) begin
                x = $urandom;
                y = $urandom;
                o = 2'($urandom_range(0, 3));
                p = clmul_ref(x, y);
                issue(o, x, y, ref_sel(o, p), p[31:0], p[63:32], 100 + i);
            end
            drain();

            n_done++;
        end
    end

    initial begin
        int t = 0;
        while (n_done < 3 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (n_done < 3) begin
            n_checks++;
            n_fail++;
            $display("FAIL global_timeout: got %0d instances done required 3", n_done);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
